// File: rtl/i2s_xmit.sv
// ---------------------------------------------------------------------------
// i2s_xmit -- I2S serial transmitter (DAC output stage)
//
// Accepts 24-bit left/right sample pairs over a valid/ready handshake into a
// one-pair holding buffer and serialises them MSB-first onto sdout, framed by
// the bck/lrck produced by clk_div. Everything runs on posedge mck; bck and
// lrck are sampled as data, never used as clocks.
//
// Parameters
//   WIDTH  sample bits per channel
//   SLOT   bck periods per channel half-frame (WIDTH + DELAY <= SLOT, SLOT <= 64)
//   DELAY  bck periods from lrck edge to MSB (1 = I2S, 0 = left-justified)
//
// Ports
//   mck        in   system clock
//   reset      in   synchronous, active-high reset
//   bck        in   bit clock (mck-synchronous)
//   lrck       in   frame clock, 0 = left, 1 = right
//   l_in       in   left sample, two's complement
//   r_in       in   right sample, two's complement
//   in_valid   in   l_in/r_in pair valid
//   in_ready   out  holding buffer can accept a pair
//   sdout      out  serial data to DAC (registered)
//   underrun   out  1-mck pulse: left start with no pair buffered
//   frame_sof  out  1-mck pulse at every left-channel start
//
// Build option
//   I2S_XMIT_HOLD_LAST_EN  when defined, an underrun repeats the last pair
//                          loaded for transmission instead of sending zeros.
// ---------------------------------------------------------------------------
module i2s_xmit #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned SLOT  = 32,
    parameter int unsigned DELAY = 1
) (
    input  logic             mck,
    input  logic             reset,
    input  logic             bck,
    input  logic             lrck,
    input  logic [WIDTH-1:0] l_in,
    input  logic [WIDTH-1:0] r_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sdout,
    output logic             underrun,
    output logic             frame_sof
);

    localparam int unsigned BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [6:0]  DELAY7  = 7'(DELAY);
    localparam logic [6:0]  WIDTH7  = 7'(WIDTH);
    localparam logic [6:0]  TOP7    = 7'(WIDTH - 1);
    localparam logic [5:0]  IDX_MAX = 6'(SLOT - 1);

    // DISARMED: waiting to see lrck=1 on a bck fall.
    // ARMED:    waiting for the first left start (1->0 lrck edge).
    // RUN:      transmitting; left starts load / underrun.
    typedef enum logic [1:0] {
        ST_DISARMED,
        ST_ARMED,
        ST_RUN
    } state_e;

    state_e           state_q,     state_d;
    logic             bck_q;
    logic             lrck_q,      lrck_d;
    logic             full_q,      full_d;
    logic [WIDTH-1:0] l_hold_q,    l_hold_d;
    logic [WIDTH-1:0] r_hold_q,    r_hold_d;
    logic [WIDTH-1:0] l_sh_q,      l_sh_d;
    logic [WIDTH-1:0] r_sh_q,      r_sh_d;
    logic [WIDTH-1:0] r_pend_q,    r_pend_d;
    logic [5:0]       idx_q,       idx_d;
    logic             right_q,     right_d;
    logic             sdout_q,     sdout_d;
    logic             underrun_q,  underrun_d;
    logic             sof_q,       sof_d;
`ifdef I2S_XMIT_HOLD_LAST_EN
    logic [WIDTH-1:0] last_l_q,    last_l_d;
    logic [WIDTH-1:0] last_r_q,    last_r_d;
`endif

    logic             bck_fall;
    logic             chan_start;
    logic             left_start;
    logic             right_start;
    logic             accept;
    logic [WIDTH-1:0] word;
    logic [6:0]       off;
    logic [BW-1:0]    bitpos;

    assign bck_fall    = bck_q & ~bck;
    assign chan_start  = bck_fall & (lrck != lrck_q);
    assign left_start  = chan_start & ~lrck;
    assign right_start = chan_start &  lrck;
    assign accept      = in_valid & ~full_q;

    always_comb begin
        state_d    = state_q;
        lrck_d     = lrck_q;
        full_d     = full_q;
        l_hold_d   = l_hold_q;
        r_hold_d   = r_hold_q;
        l_sh_d     = l_sh_q;
        r_sh_d     = r_sh_q;
        r_pend_d   = r_pend_q;
        idx_d      = idx_q;
        right_d    = right_q;
        sdout_d    = sdout_q;
        underrun_d = 1'b0;
        sof_d      = 1'b0;
`ifdef I2S_XMIT_HOLD_LAST_EN
        last_l_d   = last_l_q;
        last_r_d   = last_r_q;
`endif
        word       = '0;
        off        = '0;
        bitpos     = '0;

        if (accept) begin
            l_hold_d = l_in;
            r_hold_d = r_in;
            full_d   = 1'b1;
        end

        if (bck_fall) begin
            lrck_d = lrck;

            case (state_q)
                ST_DISARMED: if (lrck)       state_d = ST_ARMED;
                ST_ARMED:    if (left_start) state_d = ST_RUN;
                default:     ;
            endcase

            if (chan_start) begin
                idx_d   = '0;
                right_d = lrck;
            end else if (idx_q != IDX_MAX) begin
                idx_d = idx_q + 6'd1;
            end

            // Buffer is drained only by a left start that finds it already full;
            // a pair accepted in this very cycle waits for the next frame.
            if (left_start && (state_q != ST_DISARMED)) begin
                sof_d = 1'b1;
                if (full_q) begin
                    l_sh_d   = l_hold_q;
                    r_pend_d = r_hold_q;
                    full_d   = 1'b0;
`ifdef I2S_XMIT_HOLD_LAST_EN
                    last_l_d = l_hold_q;
                    last_r_d = r_hold_q;
`endif
                end else begin
                    underrun_d = 1'b1;
`ifdef I2S_XMIT_HOLD_LAST_EN
                    l_sh_d   = last_l_q;
                    r_pend_d = last_r_q;
`else
                    l_sh_d   = '0;
                    r_pend_d = '0;
`endif
                end
            end

            if (right_start) begin
                r_sh_d = r_pend_q;
            end

            // Bit selection uses the post-update index and word so that the
            // channel-start fall itself emits slot 0.
            word   = right_d ? r_sh_d : l_sh_d;
            off    = {1'b0, idx_d} - DELAY7;
            bitpos = BW'(TOP7 - off);
            if ((state_d == ST_RUN) && !off[6] && (off < WIDTH7)) begin
                sdout_d = word[bitpos];
            end else begin
                sdout_d = 1'b0;
            end
        end
    end

    always_ff @(posedge mck) begin
        if (reset) begin
            state_q    <= ST_DISARMED;
            bck_q      <= 1'b0;
            lrck_q     <= 1'b0;
            full_q     <= 1'b0;
            l_hold_q   <= '0;
            r_hold_q   <= '0;
            l_sh_q     <= '0;
            r_sh_q     <= '0;
            r_pend_q   <= '0;
            idx_q      <= '0;
            right_q    <= 1'b0;
            sdout_q    <= 1'b0;
            underrun_q <= 1'b0;
            sof_q      <= 1'b0;
`ifdef I2S_XMIT_HOLD_LAST_EN
            last_l_q   <= '0;
            last_r_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bck_q      <= bck;
            lrck_q     <= lrck_d;
            full_q     <= full_d;
            l_hold_q   <= l_hold_d;
            r_hold_q   <= r_hold_d;
            l_sh_q     <= l_sh_d;
            r_sh_q     <= r_sh_d;
            r_pend_q   <= r_pend_d;
            idx_q      <= idx_d;
            right_q    <= right_d;
            sdout_q    <= sdout_d;
            underrun_q <= underrun_d;
            sof_q      <= sof_d;
`ifdef I2S_XMIT_HOLD_LAST_EN
            last_l_q   <= last_l_d;
            last_r_q   <= last_r_d;
`endif
        end
    end

    assign in_ready  = ~full_q;
    assign sdout     = sdout_q;
    assign underrun  = underrun_q;
    assign frame_sof = sof_q;

endmodule

// File: tb/tb_i2s_xmit.sv
// ---------------------------------------------------------------------------
// tb_i2s_xmit -- directed bench for i2s_xmit.
// A free-running divider models clk_div: bck = mck/4, 64 bck per frame,
// lrck = 0 for the left half. Two instances share stimulus: DELAY=1 (I2S)
// and DELAY=0 (left-justified).
// ---------------------------------------------------------------------------
module tb_i2s_xmit;

    localparam int unsigned W = 24;

    logic         mck      = 1'b0;
    logic         reset    = 1'b1;
    logic [7:0]   div_q    = 8'd0;
    logic         bck;
    logic         lrck;
    logic [W-1:0] l_in     = '0;
    logic [W-1:0] r_in     = '0;
    logic         in_valid = 1'b0;
    logic         in_ready,  sdout,  underrun,  frame_sof;
    logic         in_ready0, sdout0, underrun0, frame_sof0;

    int unsigned  n_cmp = 0;
    int unsigned  n_bad = 0;

    logic [W-1:0] pl [4] = '{24'h800001, 24'h7FFFFE, 24'h000100, 24'hC3C3C3};
    logic [W-1:0] pr [4] = '{24'h0F0F0F, 24'hFFFFFF, 24'h000001, 24'h5A5A5A};

    always #5 mck = ~mck;
    always @(posedge mck) div_q <= div_q + 8'd1;
    assign bck  = div_q[1];
    assign lrck = div_q[7];

    i2s_xmit #(.WIDTH(24), .SLOT(32), .DELAY(1)) dut (
        .mck(mck), .reset(reset), .bck(bck), .lrck(lrck),
        .l_in(l_in), .r_in(r_in), .in_valid(in_valid), .in_ready(in_ready),
        .sdout(sdout), .underrun(underrun), .frame_sof(frame_sof)
    );

    i2s_xmit #(.WIDTH(24), .SLOT(32), .DELAY(0)) dut0 (
        .mck(mck), .reset(reset), .bck(bck), .lrck(lrck),
        .l_in(l_in), .r_in(r_in), .in_valid(in_valid), .in_ready(in_ready0),
        .sdout(sdout0), .underrun(underrun0), .frame_sof(frame_sof0)
    );

    function automatic logic [0:63] exp_i2s(input logic [W-1:0] l, input logic [W-1:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    function automatic logic [0:63] exp_lj(input logic [W-1:0] l, input logic [W-1:0] r);
        return {l, 8'b0, r, 8'b0};
    endfunction

    task automatic wait_div(input logic [7:0] v);
        int unsigned guard = 0;
        do begin
            @(negedge mck);
            guard++;
        end while ((div_q != v) && (guard < 600));
        if (div_q != v) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_div: got div %0d expected %0d", div_q, v);
        end
    endtask

    // Captures one frame starting at the negedge right after a left start.
    // Slot i of the frame is sampled at the negedge where div == 4*i+1.
    task automatic grab_frame(output logic [0:63] f1, output logic [0:63] f0,
                              output int unsigned sofs, output int unsigned urs,
                              output logic rdy1, output logic rdy2);
        f1 = '0; f0 = '0; sofs = 0; urs = 0; rdy1 = 1'b0; rdy2 = 1'b0;
        wait_div(8'd1);
        for (int n = 0; n < 256; n++) begin
            if (n > 0) @(negedge mck);
            if (div_q[1:0] == 2'b01) begin
                f1[div_q[7:2]] = sdout;
                f0[div_q[7:2]] = sdout0;
            end
            if (frame_sof) sofs++;
            if (underrun)  urs++;
            if (n == 0) rdy1 = in_ready;
            if (n == 1) rdy2 = in_ready;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge mck);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++;
        if (sdout !== 1'b0) begin n_bad++; $display("FAIL reset_sdout: got %b expected 0", sdout); end
        n_cmp++;
        if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        n_cmp++;
        if (frame_sof !== 1'b0) begin n_bad++; $display("FAIL reset_sof: got %b expected 0", frame_sof); end
        n_cmp++;
        if (sdout0 !== 1'b0) begin n_bad++; $display("FAIL reset_sdout_d0: got %b expected 0", sdout0); end
        wait_div(8'd64);
        reset = 1'b0;
    endtask

    task automatic test_single_pair;
        logic [0:63] f1, f0;
        int unsigned sofs, urs;
        logic        r1, r2;
        l_in = 24'hA5F00F; r_in = 24'h123456; in_valid = 1'b1;
        @(negedge mck);
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL t1_ready_drop: got %b expected 0", in_ready); end
        grab_frame(f1, f0, sofs, urs, r1, r2);
        n_cmp++;
        if (f1 !== exp_i2s(24'hA5F00F, 24'h123456)) begin
            n_bad++; $display("FAIL t1_frame: got %h expected %h", f1, exp_i2s(24'hA5F00F, 24'h123456));
        end
        n_cmp++;
        if (f0 !== exp_lj(24'hA5F00F, 24'h123456)) begin
            n_bad++; $display("FAIL t1_frame_delay0: got %h expected %h", f0, exp_lj(24'hA5F00F, 24'h123456));
        end
        n_cmp++;
        if (sofs != 1) begin n_bad++; $display("FAIL t1_sof_count: got %0d expected 1", sofs); end
        n_cmp++;
        if (urs != 0) begin n_bad++; $display("FAIL t1_underrun_count: got %0d expected 0", urs); end
        n_cmp++;
        if (r1 !== 1'b1) begin n_bad++; $display("FAIL t1_ready_after_sof: got %b expected 1", r1); end
        n_cmp++;
        if (r2 !== 1'b1) begin n_bad++; $display("FAIL t1_ready_idle: got %b expected 1", r2); end
    endtask

    task automatic test_underrun;
        logic [0:63] f1, f0, e1, e0;
        int unsigned sofs, urs;
        logic        r1, r2;
`ifdef I2S_XMIT_HOLD_LAST_EN
        e1 = exp_i2s(24'hA5F00F, 24'h123456);
        e0 = exp_lj(24'hA5F00F, 24'h123456);
`else
        e1 = '0;
        e0 = '0;
`endif
        grab_frame(f1, f0, sofs, urs, r1, r2);
        n_cmp++;
        if (f1 !== e1) begin n_bad++; $display("FAIL t2_frame: got %h expected %h", f1, e1); end
        n_cmp++;
        if (f0 !== e0) begin n_bad++; $display("FAIL t2_frame_delay0: got %h expected %h", f0, e0); end
        n_cmp++;
        if (urs != 1) begin n_bad++; $display("FAIL t2_underrun_count: got %0d expected 1", urs); end
        n_cmp++;
        if (sofs != 1) begin n_bad++; $display("FAIL t2_sof_count: got %0d expected 1", sofs); end
    endtask

    task automatic test_back_to_back;
        wait_div(8'd64);
        fork
            begin : driver
                for (int k = 0; k < 4; k++) begin
                    int unsigned guard;
                    logic        got;
                    l_in = pl[k]; r_in = pr[k]; in_valid = 1'b1;
                    guard = 0; got = 1'b0;
                    while (!got && (guard < 700)) begin
                        if (in_ready) got = 1'b1;
                        @(negedge mck);
                        guard++;
                    end
                    n_cmp++;
                    if (!got) begin
                        n_bad++; $display("FAIL t3_accept_timeout: pair %0d not accepted in %0d cycles", k, guard);
                    end else if (in_ready !== 1'b0) begin
                        n_bad++; $display("FAIL t3_ready_drop: pair %0d got %b expected 0", k, in_ready);
                    end
                end
                in_valid = 1'b0;
            end
            begin : grabber
                for (int k = 0; k < 3; k++) begin
                    logic [0:63] f1, f0;
                    int unsigned sofs, urs;
                    logic        r1, r2;
                    grab_frame(f1, f0, sofs, urs, r1, r2);
                    n_cmp++;
                    if (f1 !== exp_i2s(pl[k], pr[k])) begin
                        n_bad++; $display("FAIL t3_frame%0d: got %h expected %h", k, f1, exp_i2s(pl[k], pr[k]));
                    end
                    n_cmp++;
                    if (urs != 0) begin n_bad++; $display("FAIL t3_underrun%0d: got %0d expected 0", k, urs); end
                    n_cmp++;
                    if (r1 !== 1'b1) begin n_bad++; $display("FAIL t3_ready_rise%0d: got %b expected 1", k, r1); end
                    n_cmp++;
                    if (r2 !== 1'b0) begin n_bad++; $display("FAIL t3_refill%0d: got %b expected 0", k, r2); end
                end
            end
        join
        begin
            logic [0:63] f1, f0;
            int unsigned sofs, urs;
            logic        r1, r2;
            grab_frame(f1, f0, sofs, urs, r1, r2);
            n_cmp++;
            if (f1 !== exp_i2s(pl[3], pr[3])) begin
                n_bad++; $display("FAIL t3_last_pair: got %h expected %h", f1, exp_i2s(pl[3], pr[3]));
            end
            n_cmp++;
            if (f0 !== exp_lj(pl[3], pr[3])) begin
                n_bad++; $display("FAIL t3_last_pair_delay0: got %h expected %h", f0, exp_lj(pl[3], pr[3]));
            end
        end
    endtask

    // Previous grab ends on the negedge before the left-start posedge.
    task automatic test_accept_at_sof;
        logic [0:63] f1, f0;
        int unsigned sofs, urs;
        logic        r1, r2;
        n_cmp++;
        if (div_q != 8'd0) begin n_bad++; $display("FAIL t4_align: got div %0d expected 0", div_q); end
        l_in = 24'h13579B; r_in = 24'h2468AC; in_valid = 1'b1;
        @(negedge mck);
        in_valid = 1'b0;
        n_cmp++;
        if (underrun !== 1'b1) begin n_bad++; $display("FAIL t4_underrun: got %b expected 1", underrun); end
        n_cmp++;
        if (frame_sof !== 1'b1) begin n_bad++; $display("FAIL t4_sof: got %b expected 1", frame_sof); end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL t4_pair_kept: in_ready got %b expected 0", in_ready); end
        grab_frame(f1, f0, sofs, urs, r1, r2);
        n_cmp++;
        if (f1 !== exp_i2s(24'h13579B, 24'h2468AC)) begin
            n_bad++; $display("FAIL t4_next_frame: got %h expected %h", f1, exp_i2s(24'h13579B, 24'h2468AC));
        end
        n_cmp++;
        if (urs != 0) begin n_bad++; $display("FAIL t4_next_underrun: got %0d expected 0", urs); end
    endtask

    task automatic test_reset_mid_frame;
        logic [0:63] f1, f0;
        int unsigned sofs, urs, stray;
        logic        r1, r2;
        wait_div(8'd64);
        l_in = 24'hFFFFFF; r_in = 24'hFFFFFF; in_valid = 1'b1;
        @(negedge mck);
        in_valid = 1'b0;
        wait_div(8'd20);
        l_in = 24'hABCDEF; r_in = 24'hFEDCBA; in_valid = 1'b1;
        @(negedge mck);
        in_valid = 1'b0;
        wait_div(8'd161);
        n_cmp++;
        if (sdout !== 1'b1) begin n_bad++; $display("FAIL t6_pre_sdout: got %b expected 1", sdout); end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL t6_pre_ready: got %b expected 0", in_ready); end
        reset = 1'b1;
        @(negedge mck);
        n_cmp++;
        if (sdout !== 1'b0) begin n_bad++; $display("FAIL t6_sdout_cleared: got %b expected 0", sdout); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL t6_ready_reset: got %b expected 1", in_ready); end
        wait_div(8'd170);
        reset = 1'b0;
        stray = 0;
        do begin
            @(negedge mck);
            if (div_q == 8'd200) begin l_in = 24'h00F00D; r_in = 24'hBEEF00; in_valid = 1'b1; end
            if (div_q == 8'd201) in_valid = 1'b0;
            if (sdout || sdout0 || underrun || frame_sof) stray++;
        end while (div_q != 8'd0);
        n_cmp++;
        if (stray != 0) begin n_bad++; $display("FAIL t6_quiet_after_reset: got %0d active cycles expected 0", stray); end
        grab_frame(f1, f0, sofs, urs, r1, r2);
        n_cmp++;
        if (f1 !== exp_i2s(24'h00F00D, 24'hBEEF00)) begin
            n_bad++; $display("FAIL t6_first_frame: got %h expected %h", f1, exp_i2s(24'h00F00D, 24'hBEEF00));
        end
        n_cmp++;
        if (sofs != 1) begin n_bad++; $display("FAIL t6_sof_count: got %0d expected 1", sofs); end
        n_cmp++;
        if (urs != 0) begin n_bad++; $display("FAIL t6_underrun_count: got %0d expected 0", urs); end
    endtask

    initial begin
        test_reset;
        test_single_pair;
        test_underrun;
        test_back_to_back;
        test_accept_at_sof;
        test_reset_mid_frame;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
